prim_ram_1p_init_ctrl: RTL and testbench

- Front-end controller sitting directly upstream of the single-port RAM primitive with bad-bit injection; drives its req/write/addr/wdata/wmask inputs and consumes its rdata output.
- After reset, or on request, sequentially zero-fills the whole array.
- Then arbitrates host accesses through a req/gnt/rvalid handshake, rejects out-of-range addresses and returns read data with a fixed one-cycle latency.

---
 rtl/prim_ram_1p_init_ctrl.sv | 164 ++++++++++++++++
 tb/tb_prim_ram_1p_init_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_ram_1p_init_ctrl.sv
// ---------------------------------------------------------------------------
// prim_ram_1p_init_ctrl
//
// Front-end controller for a single-port RAM primitive. After reset, or when
// init_req_i is pulsed while host access is open, it zero-fills every word of
// the array, one word per cycle. Once the fill completes it opens the array
// to a host through a req/gnt handshake. Reads return one cycle after the
// grant on rvalid_o/rdata_o. Out-of-range addresses are granted but never
// reach the RAM. Such reads answer with rerror_o set and zero data, and such
// writes are dropped.
//
// Ports:
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   init_req_i         pulse: re-initialise the array (honoured in READY only)
//   init_done_o        array initialised, host access open
//   req_i / gnt_o      host request / grant (same cycle)
//   we_i, addr_i       host write enable, word address
//   wdata_i, wmask_i   host write data, per-bit write mask
//   rvalid_o           read response valid (one cycle after a granted read)
//   rdata_o            read data, forced to 0 unless a good response is valid
//   rerror_o           response is for an out-of-range read
//   ram_*_o            request side of the RAM primitive
//   ram_rdata_i        RAM read data, valid one cycle after a read request
// ---------------------------------------------------------------------------
module prim_ram_1p_init_ctrl #(
  parameter  int Width = 32,
  parameter  int Depth = 128,
  localparam int Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             init_req_i,
  output logic             init_done_o,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic             we_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic             rvalid_o,
  output logic [Width-1:0] rdata_o,
  output logic             rerror_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {
    RST_IDLE = 2'd0,
    INIT     = 2'd1,
    READY    = 2'd2
  } state_e;

  // One extra bit so that Depth itself is representable even when Depth is
  // an exact power of two.
  localparam logic [Aw:0]   DepthW   = (Aw + 1)'(Depth);
  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  function automatic logic addr_in_range(input logic [Aw-1:0] a);
    return ({1'b0, a} < DepthW);
  endfunction

  state_e        state;
  logic [Aw-1:0] count;
  logic          init_done_q;

  logic          in_range;
  logic          host_open;
  logic          host_gnt;
  logic          host_rd;

  logic          rvalid_p1;
  logic          rerror_p1;

  // Host access is closed in the cycle a re-init request arrives, so the
  // re-init always wins over a simultaneous host request.
  always_comb begin
    in_range  = addr_in_range(addr_i);
    host_open = (state == READY) && !init_req_i;
    host_gnt  = host_open && req_i;
    host_rd   = host_gnt && !we_i;
  end

  always_comb begin
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
    if (state == INIT) begin
      ram_req_o   = 1'b1;
      ram_write_o = 1'b1;
      ram_addr_o  = count;
      ram_wdata_o = '0;
      ram_wmask_o = '1;
    end else if (host_open) begin
      ram_req_o   = req_i && in_range;
      ram_write_o = we_i;
      ram_addr_o  = addr_i;
      ram_wdata_o = wdata_i;
      ram_wmask_o = wmask_i;
    end
  end

  // Init sequencer. The counter is cleared on the final fill write rather
  // than wrapping, so it never holds a value past Depth-1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= RST_IDLE;
      count       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state)
        RST_IDLE: begin
          state       <= INIT;
          count       <= '0;
          init_done_q <= 1'b0;
        end
        INIT: begin
          if (count == LastAddr) begin
            state       <= READY;
            count       <= '0;
            init_done_q <= 1'b1;
          end else begin
            count <= count + Aw'(1);
          end
        end
        READY: begin
          if (init_req_i) begin
            state       <= INIT;
            count       <= '0;
            init_done_q <= 1'b0;
          end
        end
        default: begin
          state       <= RST_IDLE;
          count       <= '0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p1: read response, one cycle after the grant ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_p1 <= 1'b0;
      rerror_p1 <= 1'b0;
    end else begin
      rvalid_p1 <= host_rd;
      rerror_p1 <= host_rd && !in_range;
    end
  end

  assign init_done_o = init_done_q;
  assign gnt_o       = host_gnt;
  assign rvalid_o    = rvalid_p1;
  assign rerror_o    = rerror_p1;
  assign rdata_o     = (rvalid_p1 && !rerror_p1) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_prim_ram_1p_init_ctrl.sv
module tb_prim_ram_1p_init_ctrl;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main instance, Depth=128
  logic          init_req;
  logic          init_done_o, gnt_o, rvalid_o, rerror_o;
  logic          req, we;
  logic [6:0]    addr;
  logic [W-1:0]  wdata, wmask;
  logic [W-1:0]  rdata_o;
  logic          ram_req_o, ram_write_o;
  logic [6:0]    ram_addr_o;
  logic [W-1:0]  ram_wdata_o, ram_wmask_o;
  logic [W-1:0]  ram_rdata;

  // Second instance, Depth=100, for out-of-range addresses
  logic          init_req100;
  logic          init_done100, gnt100, rvalid100, rerror100;
  logic          req100, we100;
  logic [6:0]    addr100;
  logic [W-1:0]  wdata100, wmask100;
  logic [W-1:0]  rdata100;
  logic          ram_req100, ram_write100;
  logic [6:0]    ram_addr100;
  logic [W-1:0]  ram_wdata100, ram_wmask100;
  logic [W-1:0]  ram_rdata100;

  prim_ram_1p_init_ctrl #(.Width(W), .Depth(128)) dut (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req), .init_done_o(init_done_o),
    .req_i(req), .gnt_o(gnt_o), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .wmask_i(wmask), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rerror_o(rerror_o),
    .ram_req_o(ram_req_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o), .ram_rdata_i(ram_rdata)
  );

  prim_ram_1p_init_ctrl #(.Width(W), .Depth(100)) dut100 (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req100), .init_done_o(init_done100),
    .req_i(req100), .gnt_o(gnt100), .we_i(we100), .addr_i(addr100), .wdata_i(wdata100),
    .wmask_i(wmask100), .rvalid_o(rvalid100), .rdata_o(rdata100), .rerror_o(rerror100),
    .ram_req_o(ram_req100), .ram_write_o(ram_write100), .ram_addr_o(ram_addr100),
    .ram_wdata_o(ram_wdata100), .ram_wmask_o(ram_wmask100), .ram_rdata_i(ram_rdata100)
  );

  // Behavioural RAM behind the main instance, preloaded with non-zero junk
  // so that the zero-fill is observable.
  logic [W-1:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = 32'h1234_0000 + 32'(i);

  always @(posedge clk) begin
    if (ram_req_o) begin
      if (ram_write_o)
        mem[ram_addr_o] <= (mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
      else
        ram_rdata <= mem[ram_addr_o];
    end
  end

  // The second instance only needs a recognisable read-data pattern.
  assign ram_rdata100 = 32'hA5A5_A5A5;

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboards: {rerror, rdata} expected per response
  logic [32:0] q [$];
  logic [32:0] q100 [$];
  logic [32:0] exp_v, exp_v100;

  always @(negedge clk) begin
    if (rvalid_o) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected got rvalid=1 want none at %0t", $time);
      end else begin
        exp_v = q.pop_front();
        check_bit("rsp_err", rerror_o, exp_v[32]);
        check32("rsp_data", rdata_o, exp_v[31:0]);
      end
    end else begin
      check32("rdata_idle", rdata_o, 32'h0);
    end
  end

  always @(negedge clk) begin
    if (rvalid100) begin
      if (q100.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp100_unexpected got rvalid=1 want none at %0t", $time);
      end else begin
        exp_v100 = q100.pop_front();
        check_bit("rsp100_err", rerror100, exp_v100[32]);
        check32("rsp100_data", rdata100, exp_v100[31:0]);
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [6:0] a,
                       input logic [W-1:0] d, input logic [W-1:0] m);
    @(posedge clk); #1;
    req = r; we = w; addr = a; wdata = d; wmask = m;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_done"},   init_done_o, 1'b0);
    check_bit({tag, "_gnt"},    gnt_o,       1'b0);
    check_bit({tag, "_ramreq"}, ram_req_o,   1'b0);
    check_bit({tag, "_rvalid"}, rvalid_o,    1'b0);
    check_bit({tag, "_rerror"}, rerror_o,    1'b0);
    check32({tag, "_rdata"},    rdata_o,     32'h0);
  endtask

  // Follows one fill from address 0. Optionally pulses init_req at fill index
  // pulse_at (must be ignored), or asserts reset at index abort_at.
  task automatic do_fill(input int abort_at, input int pulse_at);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      check32("fill_addr", 32'(ram_addr_o), 32'(i));
      check32("fill_ctl", {28'h0, ram_req_o, ram_write_o, gnt_o, init_done_o}, 32'hC);
      check32("fill_wdata", ram_wdata_o, 32'h0);
      check32("fill_wmask", ram_wmask_o, 32'hFFFF_FFFF);
      init_req = (i == pulse_at);
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midinit_rst");
        return;
      end
    end
    init_req = 1'b0;
  endtask

  // The host keeps a read request held through the fill; it is granted in the
  // first READY cycle and must return zero.
  task automatic post_fill();
    @(negedge clk);
    check_bit("done_rise", init_done_o, 1'b1);
    check_bit("gnt_after_fill", gnt_o, 1'b1);
    check_bit("ramreq_after_fill", ram_req_o, 1'b1);
    q.push_back({1'b0, 32'h0});
  endtask

  initial begin
    rst_n = 1'b0; init_req = 1'b0;
    req = 1'b1; we = 1'b0; addr = 7'd0; wdata = '0; wmask = '0;
    init_req100 = 1'b0; req100 = 1'b0; we100 = 1'b0; addr100 = 7'd0;
    wdata100 = '0; wmask100 = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check_bit("reset_done100", init_done100, 1'b0);

    // Reset release: one idle cycle, then the 128-word fill
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_bit("idle_ramreq", ram_req_o, 1'b0);
    check_bit("idle_gnt", gnt_o, 1'b0);
    do_fill(-1, -1);
    post_fill();

    // Write then read
    drive(1'b1, 1'b1, 7'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    @(negedge clk);
    check_bit("wr_gnt", gnt_o, 1'b1);
    check32("wr_ram", {24'h0, ram_req_o, ram_addr_o}, {24'h0, 1'b1, 7'd5});
    check_bit("wr_ramwrite", ram_write_o, 1'b1);
    check32("wr_wdata", ram_wdata_o, 32'hDEAD_BEEF);

    drive(1'b1, 1'b0, 7'd5, 32'h0, 32'h0);
    q.push_back({1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    check_bit("rd_gnt", gnt_o, 1'b1);
    check_bit("rd_ramwrite", ram_write_o, 1'b0);

    // Masked write into a freshly zeroed word
    drive(1'b1, 1'b1, 7'd9, 32'hFFFF_FFFF, 32'h0000_FFFF);
    @(negedge clk);
    check32("mwr_wmask", ram_wmask_o, 32'h0000_FFFF);

    // Back-to-back reads
    drive(1'b1, 1'b0, 7'd9, 32'h0, 32'h0);
    q.push_back({1'b0, 32'h0000_FFFF});
    drive(1'b1, 1'b0, 7'd5, 32'h0, 32'h0);
    q.push_back({1'b0, 32'hDEAD_BEEF});
    drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0);
    @(negedge clk);
    check_bit("idle_gnt2", gnt_o, 1'b0);

    // Out-of-range accesses on the Depth=100 instance
    @(posedge clk); #1;
    req100 = 1'b1; we100 = 1'b0; addr100 = 7'd120;
    q100.push_back({1'b1, 32'h0});
    @(negedge clk);
    check_bit("oor_rd_gnt", gnt100, 1'b1);
    check_bit("oor_rd_ramreq", ram_req100, 1'b0);
    @(posedge clk); #1;
    addr100 = 7'd99;
    q100.push_back({1'b0, 32'hA5A5_A5A5});
    @(negedge clk);
    check_bit("last_rd_gnt", gnt100, 1'b1);
    check_bit("last_rd_ramreq", ram_req100, 1'b1);
    @(posedge clk); #1;
    we100 = 1'b1; addr100 = 7'd127; wdata100 = 32'h1111_1111; wmask100 = '1;
    @(negedge clk);
    check_bit("oor_wr_gnt", gnt100, 1'b1);
    check_bit("oor_wr_ramreq", ram_req100, 1'b0);
    @(posedge clk); #1;
    req100 = 1'b0; we100 = 1'b0;

    // Re-init with a read in flight
    drive(1'b1, 1'b0, 7'd5, 32'h0, 32'h0);
    q.push_back({1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    check_bit("inflight_gnt", gnt_o, 1'b1);
    @(posedge clk); #1;
    init_req = 1'b1;
    @(negedge clk);
    check_bit("reinit_gnt", gnt_o, 1'b0);
    check_bit("reinit_ramreq", ram_req_o, 1'b0);
    @(posedge clk); #1;
    init_req = 1'b0;
    do_fill(-1, 50);
    post_fill();
    drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0);

    // Reset in the middle of a fill
    @(posedge clk); #1;
    init_req = 1'b1; req = 1'b1; we = 1'b0; addr = 7'd0;
    @(posedge clk); #1;
    init_req = 1'b0;
    do_fill(40, -1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_bit("restart_idle_ramreq", ram_req_o, 1'b0);
    do_fill(-1, -1);
    post_fill();
    drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0);

    repeat (3) @(negedge clk);
    check32("queue_empty", 32'(q.size()), 32'h0);
    check32("queue100_empty", 32'(q100.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
